// File: rtl/mem_dma_pkg.sv
// Shared definitions for the word-copy DMA: register map, CTRL bit positions
// and the transfer FSM encoding.
package mem_dma_pkg;

    localparam logic [11:0] REG_SRC  = 12'h000;
    localparam logic [11:0] REG_DST  = 12'h004;
    localparam logic [11:0] REG_LEN  = 12'h008;
    localparam logic [11:0] REG_CTRL = 12'h00C;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_ERR   = 3;
    localparam int CTRL_IE    = 4;

    localparam logic [31:0] WORD_STEP = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_GAP_R = 3'd2,
        ST_WR    = 3'd3,
        ST_GAP_W = 3'd4,
        ST_DONE  = 3'd5
    } dma_state_e;

endpackage

// File: rtl/mem_dma_regs.sv
// CPU-facing register window of the DMA: cfg handshake, SRC/DST/LEN/CTRL
// storage, START decode and the W1C status bits.
module mem_dma_regs
    import mem_dma_pkg::*;
#(
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_sel,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic                cfg_wr,
    input  logic [11:0]         cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic [31:0]         cfg_rdata,
    input  logic                busy,
    input  logic                done_set,
    input  logic                err_set,
    input  logic [31:0]         wk_src,
    input  logic [31:0]         wk_dst,
    input  logic [LEN_BITS-1:0] wk_cnt,
    output logic                start_pulse,
    output logic [31:0]         src,
    output logic [31:0]         dst,
    output logic [LEN_BITS-1:0] len,
    output logic                ie,
    output logic                done
);

    logic                cfg_ready_q, cfg_ready_d;
    logic [31:0]         src_q, src_d;
    logic [31:0]         dst_q, dst_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic                ie_q, ie_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                wr_en;
    logic                ctrl_wr;
    logic                cfg_wr_ok;
    logic [31:0]         rd_word;

    assign wr_en       = cfg_ready_q & cfg_wr;
    assign ctrl_wr     = wr_en && (cfg_addr == REG_CTRL);
    assign cfg_wr_ok   = wr_en && !busy;
    assign start_pulse = ctrl_wr && cfg_wdata[CTRL_START] && !busy;

    always_comb begin
        cfg_ready_d = cfg_valid & cfg_sel & !cfg_ready_q;
        src_d  = src_q;
        dst_d  = dst_q;
        len_d  = len_q;
        ie_d   = ie_q;
        done_d = done_q;
        err_d  = err_q;
        // An abort leaves the working copies of the failing word visible.
        if (err_set) begin
            src_d = wk_src;
            dst_d = wk_dst;
            len_d = wk_cnt;
        end else if (cfg_wr_ok) begin
            if (cfg_addr == REG_SRC) src_d = {cfg_wdata[31:2], 2'b00};
            if (cfg_addr == REG_DST) dst_d = {cfg_wdata[31:2], 2'b00};
            if (cfg_addr == REG_LEN) len_d = cfg_wdata[LEN_BITS-1:0];
        end
        if (ctrl_wr) begin
            ie_d = cfg_wdata[CTRL_IE];
            if (cfg_wdata[CTRL_DONE]) done_d = 1'b0;
            if (cfg_wdata[CTRL_ERR])  err_d  = 1'b0;
        end
        if (start_pulse) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (done_set) done_d = 1'b1;
        if (err_set)  err_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_ready_q <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            ie_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cfg_ready_q <= cfg_ready_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            ie_q        <= ie_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        rd_word = '0;
        case (cfg_addr)
            REG_SRC:  rd_word = busy ? wk_src : src_q;
            REG_DST:  rd_word = busy ? wk_dst : dst_q;
            REG_LEN:  rd_word = 32'(busy ? wk_cnt : len_q);
            REG_CTRL: begin
                rd_word[CTRL_BUSY] = busy;
                rd_word[CTRL_DONE] = done_q;
                rd_word[CTRL_ERR]  = err_q;
                rd_word[CTRL_IE]   = ie_q;
            end
            default:  rd_word = '0;
        endcase
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_rdata = cfg_ready_q ? rd_word : 32'h0;
    assign src       = src_q;
    assign dst       = dst_q;
    assign len       = len_q;
    assign ie        = ie_q;
    assign done      = done_q;

endmodule

// File: rtl/mem_dma.sv
// Word-copy DMA initiator: read one word from SRC, write it to DST, repeat
// LEN times, with a bus watchdog and a level interrupt on completion.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int LEN_BITS = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_sel,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_wr,
    input  logic [11:0] cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        irq
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    localparam logic [LEN_BITS-1:0] CNT_ONE = LEN_BITS'(1);

    dma_state_e          state_q, state_d;
    logic [31:0]         src_wk_q, src_wk_d;
    logic [31:0]         dst_wk_q, dst_wk_d;
    logic [LEN_BITS-1:0] cnt_q, cnt_d;
    logic [31:0]         data_q, data_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                irq_q, irq_d;

    logic                start_pulse;
    logic [31:0]         cfg_src, cfg_dst;
    logic [LEN_BITS-1:0] cfg_len;
    logic                ie, done;
    logic                busy, done_set, err_set;
    logic                bus_active, wd_expire;

    mem_dma_regs #(
        .LEN_BITS (LEN_BITS)
    ) u_regs (
        .clk         (clk),
        .reset       (reset),
        .cfg_sel     (cfg_sel),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .busy        (busy),
        .done_set    (done_set),
        .err_set     (err_set),
        .wk_src      (src_wk_q),
        .wk_dst      (dst_wk_q),
        .wk_cnt      (cnt_q),
        .start_pulse (start_pulse),
        .src         (cfg_src),
        .dst         (cfg_dst),
        .len         (cfg_len),
        .ie          (ie),
        .done        (done)
    );

    assign bus_active = (state_q == ST_RD) || (state_q == ST_WR);
    assign wd_expire  = (TIMEOUT != 0) && (wd_q == WD_LAST) && !m_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_pulse) state_d = (cfg_len == '0) ? ST_DONE : ST_RD;
            ST_RD:    if (m_ready) state_d = ST_GAP_R;
                      else if (wd_expire) state_d = ST_IDLE;
            ST_GAP_R: state_d = ST_WR;
            ST_WR:    if (m_ready) state_d = ST_GAP_W;
                      else if (wd_expire) state_d = ST_IDLE;
            ST_GAP_W: state_d = (cnt_q != '0) ? ST_RD : ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus outputs decode straight from registered state and datapath, so they
    // hold steady through a stall and vanish at once on reset.
    always_comb begin
        m_valid  = bus_active;
        m_addr   = '0;
        m_wdata  = '0;
        m_wstrb  = 4'h0;
        busy     = (state_q != ST_IDLE);
        err_set  = bus_active && wd_expire;
        done_set = (state_q == ST_DONE) || err_set;
        if (state_q == ST_RD) begin
            m_addr = src_wk_q;
        end else if (state_q == ST_WR) begin
            m_addr  = dst_wk_q;
            m_wdata = data_q;
            m_wstrb = 4'hf;
        end
    end

    always_comb begin
        src_wk_d = src_wk_q;
        dst_wk_d = dst_wk_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        wd_d     = '0;
        if ((state_q == ST_IDLE) && start_pulse) begin
            src_wk_d = cfg_src;
            dst_wk_d = cfg_dst;
            cnt_d    = cfg_len;
        end
        if ((state_q == ST_RD) && m_ready) data_d = m_rdata;
        if ((state_q == ST_WR) && m_ready) begin
            src_wk_d = src_wk_q + WORD_STEP;
            dst_wk_d = dst_wk_q + WORD_STEP;
            cnt_d    = cnt_q - CNT_ONE;
        end
        if (bus_active && !m_ready) wd_d = wd_q + WD_ONE;
        irq_d = done & ie;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_wk_q <= '0;
            dst_wk_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            wd_q     <= '0;
            irq_q    <= 1'b0;
        end else begin
            src_wk_q <= src_wk_d;
            dst_wk_q <= dst_wk_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            wd_q     <= wd_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma: a memory responder with a beat scoreboard built
// from the copy rules, plus literal checks of registers, memory and irq timing.
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_sel, cfg_valid, cfg_ready, cfg_wr;
    logic [11:0] cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata;
    logic        m_valid, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        irq;

    always #5 clk = ~clk;

    mem_dma #(
        .LEN_BITS (16),
        .TIMEOUT  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_sel   (cfg_sel),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .irq       (irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [bit [31:0]];
    beat_t       expq [$];
    int          beats = 0;
    int          vld_cycles = 0;
    bit          seen = 1'b0;
    logic [31:0] held_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < 32'h1000 && mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Responder: RAM below 0x1000, stall in 0xF... space, void elsewhere.
    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            m_ready = 1'b0;
            seen    = 1'b0;
        end else if (m_ready) begin
            chk("vld_drop", 32'(m_valid), 32'h0);
            m_ready = 1'b0;
            seen    = 1'b0;
        end else if (m_valid) begin
            vld_cycles++;
            if (m_addr[31:28] == 4'hF) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen      = 1'b1;
                held_addr = m_addr;
            end else begin
                beats++;
                chk("addr_hold", m_addr, held_addr);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat addr %h strb %h", m_addr, m_wstrb);
                end else begin
                    e = expq.pop_front();
                    chk("beat_addr", m_addr, e.addr);
                    chk("beat_strb", 32'(m_wstrb), 32'(e.strb));
                    if (e.strb == 4'hf) chk("beat_wdata", m_wdata, e.data);
                end
                if (m_wstrb == 4'h0) m_rdata = model_read(m_addr);
                else if (m_addr < 32'h1000) mem[m_addr] = m_wdata;
                m_ready = 1'b1;
            end
        end
    end

    task automatic cfg(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
        int n;
        @(negedge clk);
        cfg_sel = 1'b1; cfg_valid = 1'b1; cfg_wr = wr; cfg_addr = a; cfg_wdata = d;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            checks++;
            errors++;
            $display("FAIL cfg_timeout addr %h got no ready required ready", a);
        end
        rd = cfg_rdata;
        @(negedge clk);
        cfg_sel = 1'b0; cfg_valid = 1'b0; cfg_wr = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        cfg(1'b1, a, d, dummy);
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        cfg(1'b0, a, 32'h0, v);
    endtask

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input int len,
                              input logic [31:0] ctrl, input bit push);
        logic [31:0] a;
        wr(12'h000, s);
        wr(12'h004, d);
        wr(12'h008, 32'(len));
        if (push) begin
            for (int i = 0; i < len; i++) begin
                a = (s & ~32'h3) + 32'(4 * i);
                expq.push_back('{a, 4'h0, 32'h0});
                expq.push_back('{(d & ~32'h3) + 32'(4 * i), 4'hf, model_read(a)});
            end
        end
        wr(12'h00C, ctrl);
    endtask

    task automatic wait_idle();
        logic [31:0] v;
        int n;
        n = 0;
        v = 32'h2;
        while (v[1] && n < 100) begin
            rd(12'h00C, v);
            n++;
        end
        if (v[1]) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout ctrl %h required busy 0", v);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        int n;
        reset = 1'b1;
        cfg_sel = 1'b0; cfg_valid = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        m_ready = 1'b0; m_rdata = '0;
        for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'h0);
        reset = 1'b0;
        rd(12'h000, v); chk("rst_src", v, 32'h0);
        rd(12'h004, v); chk("rst_dst", v, 32'h0);
        rd(12'h008, v); chk("rst_len", v, 32'h0);
        rd(12'h00C, v); chk("rst_ctrl", v, 32'h0);
        wr(12'h010, 32'hFFFF_FFFF);
        rd(12'h010, v); chk("reserved_rd", v, 32'h0);

        // Basic 4-word copy
        beats = 0;
        start_xfer(32'h100, 32'h200, 4, 32'h1, 1'b1);
        wait_idle();
        chk("t1_beats", 32'(beats), 32'd8);
        chk("t1_q_empty", 32'(expq.size()), 32'd0);
        for (int i = 0; i < 4; i++)
            chk("t1_mem", model_read(32'h200 + 32'(4 * i)), 32'hA0 + 32'(i));
        rd(12'h00C, v); chk("t1_ctrl", v, 32'h4);

        // LEN=0 completes without touching the bus
        vld_cycles = 0;
        start_xfer(32'h100, 32'h200, 0, 32'h1, 1'b1);
        rd(12'h00C, v); chk("t2_ctrl", v, 32'h4);
        chk("t2_no_valid", 32'(vld_cycles), 32'd0);

        // Write into the void region, then a stalled read hits the watchdog
        start_xfer(32'h100, 32'h3000, 1, 32'h1, 1'b1);
        wait_idle();
        chk("t3_q_empty", 32'(expq.size()), 32'd0);
        rd(12'h00C, v); chk("t3_ctrl", v, 32'h4);
        start_xfer(32'hF000_0100, 32'h200, 1, 32'h1, 1'b0);
        n = 0;
        while (!m_valid && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (m_valid && n < 100) begin n++; @(negedge clk); #1; end
        chk("t3_wd_cycles", 32'(n), 32'd16);
        rd(12'h00C, v); chk("t3_wd_ctrl", v, 32'hC);
        rd(12'h000, v); chk("t3_wd_src", v, 32'hF000_0100);
        rd(12'h008, v); chk("t3_wd_len", v, 32'h1);

        // Writes and START while busy are dropped
        beats = 0;
        start_xfer(32'h100, 32'h400, 4, 32'h1, 1'b1);
        wr(12'h000, 32'hDEAD);
        wr(12'h00C, 32'h1);
        rd(12'h00C, v); chk("t4_busy", v & 32'h2, 32'h2);
        wait_idle();
        rd(12'h000, v); chk("t4_src", v, 32'h100);
        chk("t4_beats", 32'(beats), 32'd8);
        chk("t4_q_empty", 32'(expq.size()), 32'd0);
        chk("t4_mem", model_read(32'h40C), 32'hA3);
        rd(12'h00C, v); chk("t4_ctrl", v, 32'h4);
        wr(12'h00C, 32'h4);
        rd(12'h00C, v); chk("t4_w1c", v, 32'h0);
        chk("t4_irq", 32'(irq), 32'h0);

        // irq timing with IE set
        beats = 0;
        start_xfer(32'h100, 32'h500, 2, 32'h11, 1'b1);
        n = 0;
        while (beats < 4 && n < 100) begin @(negedge clk); #1; n++; end
        chk("t5_beats", 32'(beats), 32'd4);
        repeat (3) @(negedge clk);
        chk("t5_irq_early", 32'(irq), 32'h0);
        @(negedge clk);
        chk("t5_irq_rise", 32'(irq), 32'h1);
        repeat (5) @(negedge clk);
        chk("t5_irq_hold", 32'(irq), 32'h1);
        rd(12'h00C, v); chk("t5_ctrl", v, 32'h14);
        wr(12'h00C, 32'h14);
        repeat (2) @(negedge clk);
        chk("t5_irq_clr", 32'(irq), 32'h0);

        // Reset during a write beat
        start_xfer(32'h100, 32'h600, 2, 32'h11, 1'b1);
        n = 0;
        while (!(m_valid && m_wstrb == 4'hf && !m_ready) && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("t6_in_wr", 32'(m_wstrb), 32'hF);
        reset = 1'b1;
        #1;
        chk("t6_valid_drop", 32'(m_valid), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expq.delete();
        rd(12'h000, v); chk("t6_src", v, 32'h0);
        rd(12'h004, v); chk("t6_dst", v, 32'h0);
        rd(12'h008, v); chk("t6_len", v, 32'h0);
        rd(12'h00C, v); chk("t6_ctrl", v, 32'h0);
        chk("t6_no_write", model_read(32'h600), 32'h0);
        start_xfer(32'h100, 32'h700, 1, 32'h1, 1'b1);
        wait_idle();
        chk("t6_mem", model_read(32'h700), 32'hA0);
        chk("t6_q_empty", 32'(expq.size()), 32'd0);
        rd(12'h00C, v); chk("t6_done", v, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
